// File: rtl/collision_monitor.sv
// collision_monitor: hitbox overlap check between the dinosaur and the
// cactus / pterosaur obstacles, once per video frame. A hit must persist for
// CONFIRM consecutive frame_tick samples before the game is declared Dead.
// Leaving DEAD takes a Start request after RESTART_HOLD frames have elapsed.
//
// Ports:
//   Clk, Reset          system clock, asynchronous active-high reset
//   frame_tick          one-cycle pulse per video frame (sampling strobe)
//   Start               one-cycle start / restart request
//   Dino_*              dinosaur box (top-left corner and size, signed)
//   Cactus_*, ca_off    cactus box, ignored while ca_off = 1
//   Ptero_*,  pt_off    pterosaur box, ignored while pt_off = 1
//   Dead                collision latched, obstacle drawers frozen
//   Running             game in the RUN state
//   hit_src             obstacle(s) that caused the hit: {ptero, cactus}
//   overlap_now         raw overlap result from the last frame_tick sample
module collision_monitor #(
   parameter int          MARGIN       = 6,
   parameter int unsigned CONFIRM      = 2,
   parameter int unsigned RESTART_HOLD = 30
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               frame_tick,
   input  logic               Start,
   input  logic signed [31:0] Dino_PosX,
   input  logic signed [31:0] Dino_PosY,
   input  logic signed [31:0] Dino_SizeX,
   input  logic signed [31:0] Dino_SizeY,
   input  logic signed [31:0] Cactus_PosX,
   input  logic signed [31:0] Cactus_PosY,
   input  logic signed [31:0] Cactus_SizeX,
   input  logic signed [31:0] Cactus_SizeY,
   input  logic               ca_off,
   input  logic signed [31:0] Ptero_PosX,
   input  logic signed [31:0] Ptero_PosY,
   input  logic signed [31:0] Ptero_SizeX,
   input  logic signed [31:0] Ptero_SizeY,
   input  logic               pt_off,
   output logic               Dead,
   output logic               Running,
   output logic [1:0]         hit_src,
   output logic               overlap_now
);

   localparam int unsigned CNT_W  = 4;
   localparam int unsigned HOLD_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DEAD = 2'd2
   } state_t;

   state_t              state, state_nxt;
   logic [CNT_W-1:0]    confirm_cnt, confirm_cnt_nxt;
   logic [HOLD_W-1:0]   dead_frames, dead_frames_nxt;
   logic [1:0]          hit_src_nxt;
   logic                overlap_nxt;
   logic                dead_nxt;
   logic                running_nxt;

   logic                hc, hp, ov;
   logic                confirm_reached;
   logic                restart_ok;

   // One axis of the shrunk-box test: [pa+M, pa+sa-M) against [pb+M, pb+sb-M).
   // An axis whose size is <= 2*M is empty and can never overlap, even though
   // the two strict compares alone could still succeed for a degenerate box.
   function automatic logic axis_overlap(
      input logic signed [31:0] pa,
      input logic signed [31:0] sa,
      input logic signed [31:0] pb,
      input logic signed [31:0] sb
   );
      logic signed [31:0] a_lo, a_hi, b_lo, b_hi;
      logic               a_ok, b_ok;
      a_lo = pa + 32'(MARGIN);
      a_hi = pa + sa - 32'(MARGIN);
      b_lo = pb + 32'(MARGIN);
      b_hi = pb + sb - 32'(MARGIN);
      a_ok = sa > 32'(2 * MARGIN);
      b_ok = sb > 32'(2 * MARGIN);
      return a_ok && b_ok && (a_lo < b_hi) && (b_lo < a_hi);
   endfunction

   // Per-source raw hits, qualified by the obstacle-absent flags
   always_comb begin : hit_detect
      hc = !ca_off
           && axis_overlap(Dino_PosX, Dino_SizeX, Cactus_PosX, Cactus_SizeX)
           && axis_overlap(Dino_PosY, Dino_SizeY, Cactus_PosY, Cactus_SizeY);
      hp = !pt_off
           && axis_overlap(Dino_PosX, Dino_SizeX, Ptero_PosX, Ptero_SizeX)
           && axis_overlap(Dino_PosY, Dino_SizeY, Ptero_PosY, Ptero_SizeY);
      ov = hc | hp;
   end

   assign confirm_reached = ((CNT_W+1)'(confirm_cnt) + (CNT_W+1)'(1)) == (CNT_W+1)'(CONFIRM);
   assign restart_ok      = dead_frames >= HOLD_W'(RESTART_HOLD);

   // State register
   always_ff @(posedge Clk or posedge Reset) begin : state_reg
      if (Reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic; Start out of IDLE/DEAD pre-empts any frame_tick
   always_comb begin : next_state
      state_nxt = state;
      case (state)
         IDLE:    if (Start) state_nxt = RUN;
         RUN:     if (frame_tick && ov && confirm_reached) state_nxt = DEAD;
         DEAD:    if (Start && restart_ok) state_nxt = RUN;
         default: state_nxt = IDLE;
      endcase
   end

   // Next values for counters and registered outputs
   always_comb begin : output_logic
      confirm_cnt_nxt = confirm_cnt;
      dead_frames_nxt = dead_frames;
      hit_src_nxt     = hit_src;
      overlap_nxt     = frame_tick ? ov : overlap_now;
      case (state)
         IDLE: begin
            if (Start) begin
               confirm_cnt_nxt = '0;
               dead_frames_nxt = '0;
               hit_src_nxt     = 2'b00;
            end
         end
         RUN: begin
            if (frame_tick) begin
               if (ov && confirm_reached) begin
                  hit_src_nxt     = {hp, hc};
                  dead_frames_nxt = '0;
                  confirm_cnt_nxt = '0;
               end else if (ov) begin
                  confirm_cnt_nxt = confirm_cnt + CNT_W'(1);
               end else begin
                  confirm_cnt_nxt = '0;
               end
            end
         end
         DEAD: begin
            if (Start && restart_ok) begin
               confirm_cnt_nxt = '0;
               dead_frames_nxt = '0;
               hit_src_nxt     = 2'b00;
            end else if (frame_tick && !restart_ok) begin
               // Saturates at RESTART_HOLD; nothing beyond it matters
               dead_frames_nxt = dead_frames + HOLD_W'(1);
            end
         end
         default: begin
            confirm_cnt_nxt = '0;
            dead_frames_nxt = '0;
            hit_src_nxt     = 2'b00;
         end
      endcase
      dead_nxt    = (state_nxt == DEAD);
      running_nxt = (state_nxt == RUN);
   end

   // Output and counter registers
   always_ff @(posedge Clk or posedge Reset) begin : out_reg
      if (Reset) begin
         confirm_cnt <= '0;
         dead_frames <= '0;
         hit_src     <= 2'b00;
         overlap_now <= 1'b0;
         Dead        <= 1'b0;
         Running     <= 1'b0;
      end else begin
         confirm_cnt <= confirm_cnt_nxt;
         dead_frames <= dead_frames_nxt;
         hit_src     <= hit_src_nxt;
         overlap_now <= overlap_nxt;
         Dead        <= dead_nxt;
         Running     <= running_nxt;
      end
   end

endmodule

// File: tb/tb_collision_monitor.sv
// Directed bench for collision_monitor (MARGIN=6, CONFIRM=2, RESTART_HOLD=30).
// Inputs change and outputs are sampled on the falling edge of Clk.
module tb_collision_monitor;

   logic               Clk = 1'b0;
   logic               Reset = 1'b1;
   logic               frame_tick = 1'b0;
   logic               Start = 1'b0;
   logic signed [31:0] Dino_PosX = 50, Dino_PosY = 300, Dino_SizeX = 88, Dino_SizeY = 94;
   logic signed [31:0] Cactus_PosX = 100, Cactus_PosY = 320, Cactus_SizeX = 50, Cactus_SizeY = 100;
   logic               ca_off = 1'b0;
   logic signed [31:0] Ptero_PosX = 60, Ptero_PosY = 310, Ptero_SizeX = 92, Ptero_SizeY = 80;
   logic               pt_off = 1'b1;
   logic               Dead, Running, overlap_now;
   logic [1:0]         hit_src;

   int checks = 0;
   int failures = 0;

   collision_monitor #(.MARGIN(6), .CONFIRM(2), .RESTART_HOLD(30)) dut (
      .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .Start(Start),
      .Dino_PosX(Dino_PosX), .Dino_PosY(Dino_PosY), .Dino_SizeX(Dino_SizeX), .Dino_SizeY(Dino_SizeY),
      .Cactus_PosX(Cactus_PosX), .Cactus_PosY(Cactus_PosY), .Cactus_SizeX(Cactus_SizeX), .Cactus_SizeY(Cactus_SizeY),
      .ca_off(ca_off),
      .Ptero_PosX(Ptero_PosX), .Ptero_PosY(Ptero_PosY), .Ptero_SizeX(Ptero_SizeX), .Ptero_SizeY(Ptero_SizeY),
      .pt_off(pt_off),
      .Dead(Dead), .Running(Running), .hit_src(hit_src), .overlap_now(overlap_now)
   );

   always #5 Clk = ~Clk;

   // Stimulus helpers: each starts and ends just after a falling edge
   task automatic tick();
      frame_tick = 1'b1;
      @(negedge Clk);
      frame_tick = 1'b0;
   endtask

   task automatic idle_cycle();
      @(negedge Clk);
   endtask

   task automatic press_start();
      Start = 1'b1;
      @(negedge Clk);
      Start = 1'b0;
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
      @(negedge Clk);
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (Dead !== 1'b0) begin failures++; $display("FAIL reset_dead got=%b want=0", Dead); end
      checks++; if (Running !== 1'b0) begin failures++; $display("FAIL reset_running got=%b want=0", Running); end
      checks++; if (hit_src !== 2'b00) begin failures++; $display("FAIL reset_hit_src got=%b want=00", hit_src); end
      checks++; if (overlap_now !== 1'b0) begin failures++; $display("FAIL reset_overlap got=%b want=0", overlap_now); end
   endtask

   task automatic test_basic_hit();
      Cactus_PosX = 100; ca_off = 1'b0; pt_off = 1'b1;
      press_start();
      checks++; if (Running !== 1'b1) begin failures++; $display("FAIL basic_running got=%b want=1", Running); end
      tick();
      checks++; if (overlap_now !== 1'b1) begin failures++; $display("FAIL basic_ov_t1 got=%b want=1", overlap_now); end
      checks++; if (Dead !== 1'b0) begin failures++; $display("FAIL basic_dead_t1 got=%b want=0", Dead); end
      tick();
      checks++; if (Dead !== 1'b1) begin failures++; $display("FAIL basic_dead_t2 got=%b want=1", Dead); end
      checks++; if (hit_src !== 2'b01) begin failures++; $display("FAIL basic_hit_src got=%b want=01", hit_src); end
      checks++; if (Running !== 1'b0) begin failures++; $display("FAIL basic_running_dead got=%b want=0", Running); end
   endtask

   task automatic test_edge();
      do_reset();
      Cactus_PosX = 126; ca_off = 1'b0; pt_off = 1'b1;
      press_start();
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++; if (overlap_now !== 1'b0) begin failures++; $display("FAIL edge126_ov tick=%0d got=%b want=0", i, overlap_now); end
         checks++; if (Dead !== 1'b0) begin failures++; $display("FAIL edge126_dead tick=%0d got=%b want=0", i, Dead); end
      end
      Cactus_PosX = 125;
      tick();
      checks++; if (Dead !== 1'b0) begin failures++; $display("FAIL edge125_t1 got=%b want=0", Dead); end
      tick();
      checks++; if (Dead !== 1'b1) begin failures++; $display("FAIL edge125_t2 got=%b want=1", Dead); end
   endtask

   task automatic test_confirm_restart();
      do_reset();
      Cactus_PosX = 100;
      press_start();
      tick();
      Cactus_PosX = 400;
      tick();
      checks++; if (overlap_now !== 1'b0) begin failures++; $display("FAIL gap_ov got=%b want=0", overlap_now); end
      Cactus_PosX = 100;
      tick();
      checks++; if (Dead !== 1'b0) begin failures++; $display("FAIL gap_dead_t3 got=%b want=0", Dead); end
      tick();
      checks++; if (Dead !== 1'b1) begin failures++; $display("FAIL gap_dead_t4 got=%b want=1", Dead); end
   endtask

   task automatic test_sources();
      do_reset();
      Cactus_PosX = 100; ca_off = 1'b1; pt_off = 1'b0;
      press_start();
      tick(); tick();
      checks++; if (Dead !== 1'b1) begin failures++; $display("FAIL ptero_dead got=%b want=1", Dead); end
      checks++; if (hit_src !== 2'b10) begin failures++; $display("FAIL ptero_hit_src got=%b want=10", hit_src); end
      do_reset();
      ca_off = 1'b0; pt_off = 1'b0;
      press_start();
      tick(); tick();
      checks++; if (hit_src !== 2'b11) begin failures++; $display("FAIL both_hit_src got=%b want=11", hit_src); end
   endtask

   // Continues from the DEAD state (hit_src=11) left by test_sources
   task automatic test_restart_hold();
      for (int i = 0; i < 10; i++) tick();
      press_start();
      checks++; if (Dead !== 1'b1) begin failures++; $display("FAIL early_start_dead got=%b want=1", Dead); end
      checks++; if (Running !== 1'b0) begin failures++; $display("FAIL early_start_running got=%b want=0", Running); end
      checks++; if (hit_src !== 2'b11) begin failures++; $display("FAIL early_start_hit_src got=%b want=11", hit_src); end
      for (int i = 0; i < 19; i++) tick();
      press_start();
      checks++; if (Dead !== 1'b1) begin failures++; $display("FAIL start_at29_dead got=%b want=1", Dead); end
      tick();
      press_start();
      checks++; if (Running !== 1'b1) begin failures++; $display("FAIL restart_running got=%b want=1", Running); end
      checks++; if (Dead !== 1'b0) begin failures++; $display("FAIL restart_dead got=%b want=0", Dead); end
      checks++; if (hit_src !== 2'b00) begin failures++; $display("FAIL restart_hit_src got=%b want=00", hit_src); end
   endtask

   // Start and frame_tick together in IDLE: the tick must not count toward CONFIRM
   task automatic test_start_with_tick();
      do_reset();
      ca_off = 1'b0; pt_off = 1'b1; Cactus_PosX = 100;
      Start = 1'b1; frame_tick = 1'b1;
      @(negedge Clk);
      Start = 1'b0; frame_tick = 1'b0;
      checks++; if (Running !== 1'b1) begin failures++; $display("FAIL st_running got=%b want=1", Running); end
      checks++; if (overlap_now !== 1'b1) begin failures++; $display("FAIL st_overlap got=%b want=1", overlap_now); end
      tick();
      checks++; if (Dead !== 1'b0) begin failures++; $display("FAIL st_dead_t1 got=%b want=0", Dead); end
      tick();
      checks++; if (Dead !== 1'b1) begin failures++; $display("FAIL st_dead_t2 got=%b want=1", Dead); end
   endtask

   // Continues from DEAD; Reset raised between clock edges
   task automatic test_async_reset();
      idle_cycle();
      #2 Reset = 1'b1;
      #1;
      checks++; if (Dead !== 1'b0) begin failures++; $display("FAIL async_dead got=%b want=0", Dead); end
      checks++; if (Running !== 1'b0) begin failures++; $display("FAIL async_running got=%b want=0", Running); end
      @(negedge Clk);
      Reset = 1'b0;
      tick(); tick();
      checks++; if (Running !== 1'b0) begin failures++; $display("FAIL async_no_start_running got=%b want=0", Running); end
      checks++; if (Dead !== 1'b0) begin failures++; $display("FAIL async_no_start_dead got=%b want=0", Dead); end
      press_start();
      checks++; if (Running !== 1'b1) begin failures++; $display("FAIL async_resume got=%b want=1", Running); end
   endtask

   initial begin
      @(negedge Clk);
      test_reset();
      test_basic_hit();
      test_edge();
      test_confirm_restart();
      test_sources();
      test_restart_hold();
      test_start_with_tick();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/collision_monitor.md
Name: collision_monitor

Overview:
- Downstream consumer of the cactus and pterosaur drawers.
- Takes their published bounding boxes (PosX/PosY/SizeX/SizeY plus the off flags) and the dinosaur box, then tests for hitbox overlap once per frame.
- Requires overlap on CONFIRM consecutive frames before declaring a collision.
- Owns the game's Dead flag, which freezes the obstacle drawers. A restart handshake with a minimum dead period releases it.

Parameters:
- MARGIN, 6: pixels shaved from every side of every box before testing. A box with Size <= 2*MARGIN on either axis never overlaps.
- CONFIRM, 2: consecutive overlapping frame_tick samples required to declare a hit. Legal range 1..15.
- RESTART_HOLD, 30: frame_ticks that must elapse in DEAD before Start is honoured. Legal range 0..255.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- frame_tick  in  1  single-Clk-cycle pulse, once per video frame.
- Start  in  1  single-cycle start/restart request.
- Dino_PosX, Dino_PosY  in  32 signed  dinosaur top-left corner.
- Dino_SizeX, Dino_SizeY  in  32 signed  dinosaur size.
- Cactus_PosX, Cactus_PosY, Cactus_SizeX, Cactus_SizeY  in  32 signed each  cactus box.
- ca_off  in  1  cactus absent; its box is ignored.
- Ptero_PosX, Ptero_PosY, Ptero_SizeX, Ptero_SizeY  in  32 signed each  pterosaur box.
- pt_off  in  1  pterosaur absent; its box is ignored.
- Dead  out  1  collision latched; the obstacle drawers stop moving.
- Running  out  1  game in the RUN state.
- hit_src  out  2  00 none, 01 cactus, 10 pterosaur, 11 both.
- overlap_now  out  1  registered raw overlap from the last frame_tick sample.

Behaviour:
- Reset (asynchronous, immediate):
  - State is IDLE.
  - Dead, Running, hit_src and overlap_now are 0.
  - confirm_cnt and dead_frames are 0.
  - Reset mid-frame or mid-DEAD discards all history.
- Shrunk box, per axis: lo = Pos+MARGIN, hi = Pos+Size-MARGIN, interval [lo,hi).
- Overlap test:
  - Boxes A and B overlap iff A.lo < B.hi and B.lo < A.hi on both axes.
  - All arithmetic is 32-bit signed, so negative PosX (an obstacle leaving the left edge) compares correctly.
- Per-source hits:
  - hc = cactus overlaps dino and ca_off = 0.
  - hp = pterosaur overlaps dino and pt_off = 0.
  - ov = hc | hp.
- Sampling:
  - The inputs are evaluated only in a cycle with frame_tick = 1.
  - overlap_now <= ov on every frame_tick in any state, and holds between ticks.
- FSM, registered; every transition takes effect on the clock edge that sees the condition:
  - IDLE: Running=0, Dead=0. Start → RUN, clearing confirm_cnt and hit_src. frame_tick is ignored for state purposes.
  - RUN, Running=1, on frame_tick:
    - ov=1 and confirm_cnt+1 == CONFIRM → DEAD. Latch hit_src = {hp,hc}. dead_frames=0.
    - ov=1 otherwise → confirm_cnt+1.
    - ov=0 → confirm_cnt=0.
    - Start in RUN is ignored.
  - DEAD, Dead=1, Running=0:
    - Each frame_tick: dead_frames += 1, saturating at RESTART_HOLD.
    - Start with dead_frames >= RESTART_HOLD → RUN, clearing Dead, hit_src, confirm_cnt and dead_frames.
    - Start before that is dropped, not queued.
- Latency: Dead rises the cycle after the confirming frame_tick edge. With CONFIRM=1 the hit is declared on the first overlapping tick.
- Simultaneous events:
  - Start and frame_tick in the same cycle in IDLE or DEAD: the transition to RUN wins and the tick is not evaluated against RUN.
  - In RUN, hc and hp on the same tick give hit_src=11.
- hit_src holds its latched value for the whole of DEAD.

Test Plan:
- Reset, then Start; dino (50,300,88,94), cactus (100,320,50,100), ca_off=0, pt_off=1, CONFIRM=2; two frame_ticks → overlap_now=1 after tick 1 with Dead=0; Dead=1 and hit_src=01 the cycle after tick 2.
- Cactus edge case, same dino:
  - Cactus at PosX=126 → shrunk lo=132 equals dino hi=132, so overlap_now stays 0 for 5 ticks and Dead stays 0.
  - PosX=125 → Dead after 2 ticks.
- Overlap on tick 1, clear on tick 2, overlap on tick 3 → confirm_cnt restarts, no Dead; Dead only after tick 4.
- Overlap with ca_off=1 (cactus at 100) plus pterosaur (60,310,92,80) overlapping with pt_off=0 → hit_src=10. Cactus and pterosaur both overlapping → hit_src=11.
- In DEAD with RESTART_HOLD=30:
  - Start after 10 ticks → remains DEAD.
  - Start after 30 ticks → Running=1, Dead=0, hit_src=00 next cycle.
- Assert Reset asynchronously mid-DEAD, between clock edges → Dead=0 and Running=0 immediately; Start is required to resume.
